// File: rtl/ft245_fifo_ctrl.sv
// ft245_fifo_ctrl: buffered FT245 FIFO controller with fair RD/WR arbitration; define FT245_SYNC_INPUTS_EN to synchronize txe/rxf
module ft245_fifo_ctrl #(
  parameter int RX_DEPTH     = 16,
  parameter int TX_DEPTH     = 16,
  parameter int T_RD_ACTIVE  = 4,
  parameter int T_RD_SAMPLE  = 3,
  parameter int T_DATA_TO_WR = 2,
  parameter int T_WR_ACTIVE  = 4
) (
  input  logic                      in_clk,
  input  logic                      in_rst_n,
  input  logic                      in_ftdi_txe,
  input  logic                      in_ftdi_rxf,
  inout  wire  [7:0]                io_ftdi_data,
  output logic                      out_ftdi_wr,
  output logic                      out_ftdi_rd,
  input  logic                      in_rx_en,
  input  logic [7:0]                in_tx_data,
  input  logic                      in_tx_valid,
  output logic                      out_tx_ready,
  output logic [7:0]                out_rx_data,
  output logic                      out_rx_valid,
  input  logic                      in_rx_ready,
  output logic [$clog2(RX_DEPTH):0] out_rx_level,
  output logic [$clog2(TX_DEPTH):0] out_tx_level
);
  localparam int RAW  = $clog2(RX_DEPTH);
  localparam int TAW  = $clog2(TX_DEPTH);
  localparam int TM1  = T_RD_ACTIVE > T_WR_ACTIVE ? T_RD_ACTIVE : T_WR_ACTIVE;
  localparam int TMAX = TM1 > T_DATA_TO_WR ? TM1 : T_DATA_TO_WR;
  localparam int CW   = $clog2(TMAX + 1);
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR_SETUP, S_WR, S_GAP} state_t;
  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic          r_rd, r_wr, r_oe, r_last_rd;
  logic [7:0]    r_dout;
  logic [7:0]    r_rx_mem [RX_DEPTH];
  logic [7:0]    r_tx_mem [TX_DEPTH];
  logic [RAW:0]  r_rx_wp, r_rx_rp, w_rx_level;
  logic [TAW:0]  r_tx_wp, r_tx_rp, w_tx_level;
  logic          w_rx_full, w_rx_empty, w_tx_full, w_tx_empty;
  logic          w_rx_push, w_rx_pop, w_tx_push, w_tx_pop;
  logic          w_txe, w_rxf, w_rd_req, w_wr_req, w_take_rd;
  logic [7:0]    w_tx_head;
`ifdef FT245_SYNC_INPUTS_EN
  logic [1:0] r_txe_sync, r_rxf_sync;
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      r_txe_sync <= '0;
      r_rxf_sync <= '0;
    end else begin
      r_txe_sync <= {r_txe_sync[0], in_ftdi_txe};
      r_rxf_sync <= {r_rxf_sync[0], in_ftdi_rxf};
    end
  end
  assign w_txe = r_txe_sync[1];
  assign w_rxf = r_rxf_sync[1];
`else
  assign w_txe = in_ftdi_txe;
  assign w_rxf = in_ftdi_rxf;
`endif
  assign w_rx_level = r_rx_wp - r_rx_rp;
  assign w_tx_level = r_tx_wp - r_tx_rp;
  assign w_rx_full  = w_rx_level == (RAW+1)'(RX_DEPTH);
  assign w_tx_full  = w_tx_level == (TAW+1)'(TX_DEPTH);
  assign w_rx_empty = r_rx_wp == r_rx_rp;
  assign w_tx_empty = r_tx_wp == r_tx_rp;
  assign w_tx_head  = r_tx_mem[r_tx_rp[TAW-1:0]];
  // only RD pushes into the RX FIFO, so the space check done in IDLE holds for the whole read
  assign w_rd_req   = in_rx_en & w_rxf & !w_rx_full;
  assign w_wr_req   = w_txe & !w_tx_empty;
  assign w_take_rd  = w_rd_req & (!w_wr_req | !r_last_rd);
  assign w_rx_push  = r_state == S_RD && r_cnt == CW'(T_RD_SAMPLE);
  assign w_rx_pop   = !w_rx_empty & in_rx_ready;
  assign w_tx_push  = in_tx_valid & !w_tx_full;
  assign w_tx_pop   = r_state == S_WR && r_cnt == CW'(T_WR_ACTIVE - 1);
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     w_next = w_take_rd ? S_RD : w_wr_req ? S_WR_SETUP : S_IDLE;
      S_RD:       w_next = r_cnt == CW'(T_RD_ACTIVE - 1) ? S_GAP : S_RD;
      S_WR_SETUP: w_next = r_cnt == CW'(T_DATA_TO_WR - 1) ? S_WR : S_WR_SETUP;
      S_WR:       w_next = w_tx_pop ? S_GAP : S_WR;
      default:    w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_oe      <= 1'b0;
      r_dout    <= '0;
      r_last_rd <= 1'b0;
      r_rx_wp   <= '0;
      r_rx_rp   <= '0;
      r_tx_wp   <= '0;
      r_tx_rp   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
      r_rd    <= w_next == S_RD;
      r_wr    <= w_next == S_WR;
      r_oe    <= w_next == S_WR_SETUP || w_next == S_WR;
      r_dout  <= (r_state == S_IDLE) ? w_tx_head : r_dout;
      if (r_state == S_IDLE && w_next != S_IDLE) r_last_rd <= w_next == S_RD;
      r_rx_wp <= r_rx_wp + (RAW+1)'(w_rx_push);
      r_rx_rp <= r_rx_rp + (RAW+1)'(w_rx_pop);
      r_tx_wp <= r_tx_wp + (TAW+1)'(w_tx_push);
      r_tx_rp <= r_tx_rp + (TAW+1)'(w_tx_pop);
    end
  end
  always_ff @(posedge in_clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wp[RAW-1:0]] <= io_ftdi_data;
    if (w_tx_push) r_tx_mem[r_tx_wp[TAW-1:0]] <= in_tx_data;
  end
  assign io_ftdi_data = r_oe ? r_dout : 8'hzz;
  assign out_ftdi_rd  = r_rd;
  assign out_ftdi_wr  = r_wr;
  assign out_tx_ready = !w_tx_full;
  assign out_rx_valid = !w_rx_empty;
  assign out_rx_data  = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp[RAW-1:0]];
  assign out_rx_level = w_rx_level;
  assign out_tx_level = w_tx_level;
endmodule

// File: tb/tb_ft245_fifo_ctrl.sv
// tb_ft245_fifo_ctrl: table vectors plus FTDI/consumer scoreboards for ft245_fifo_ctrl
module tb_ft245_fifo_ctrl;
  logic clk = 0, rst_n = 0, txe = 0, rxf = 0, rx_en = 0, tx_valid = 0, rx_ready = 0, tb_park = 0;
  logic [7:0] tx_data = 0, ftdi_byte = 8'hA5;
  wire  [7:0] bus;
  logic wr, rd, tx_ready, rx_valid;
  logic [7:0] rx_data;
  logic [4:0] rx_lvl, tx_lvl;
  logic tb_en;
  logic [7:0] tb_val;
  int n_vec = 0, n_err = 0, n_rd_rise = 0, n_wr_rise = 0;
  logic [7:0] rx_q[$], tx_q[$];
  int grants[$];
  logic prev_rd = 0, prev_wr = 0;
  typedef struct {
    logic rxf, txe, rdy, tv;
    logic [7:0] td;
    logic e_rd, e_wr, cb;
    logic [7:0] e_bus;
    int e_rxl, e_txl;
  } vec_t;
  vec_t tbl[16];
  assign tb_en  = rd | tb_park;
  assign tb_val = rd ? ftdi_byte : 8'h00;
  assign bus    = tb_en ? tb_val : 8'hzz;
  always #5 clk = ~clk;
  ft245_fifo_ctrl dut (
    .in_clk(clk), .in_rst_n(rst_n), .in_ftdi_txe(txe), .in_ftdi_rxf(rxf),
    .io_ftdi_data(bus), .out_ftdi_wr(wr), .out_ftdi_rd(rd), .in_rx_en(rx_en),
    .in_tx_data(tx_data), .in_tx_valid(tx_valid), .out_tx_ready(tx_ready),
    .out_rx_data(rx_data), .out_rx_valid(rx_valid), .in_rx_ready(rx_ready),
    .out_rx_level(rx_lvl), .out_tx_level(tx_lvl)
  );
  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 0;
    tick();
    rst_n = 1;
    rx_q.delete();
    tx_q.delete();
    grants.delete();
    n_rd_rise = 0;
    n_wr_rise = 0;
  endtask
  // FTDI-side model and RX consumer scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd && !prev_rd) begin
        n_rd_rise++;
        grants.push_back(1);
      end
      if (wr && !prev_wr) begin
        n_wr_rise++;
        grants.push_back(0);
        if (tx_q.size() == 0) chk("tx_unexpected", 1, 0);
        else chk("tx_byte", bus, tx_q.pop_front());
      end
      if (!rd && prev_rd) begin
        rx_q.push_back(ftdi_byte);
        ftdi_byte = ftdi_byte + 8'h1D;
      end
      if (rx_valid && rx_ready) begin
        if (rx_q.size() == 0) chk("rx_unexpected", 1, 0);
        else chk("rx_byte", rx_data, rx_q.pop_front());
      end
    end
    prev_rd = rd;
    prev_wr = wr;
  end
  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1, 0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1, 0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h3C, 0, 1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h3C, 0, 1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h3C, 0, 1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h3C, 0, 1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h3C, 0, 1};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h3C, 0, 1};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0};
    tick();
    do_reset();
    chk("rst_rd", rd, 0);
    chk("rst_wr", wr, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_level", rx_lvl, 0);
    chk("rst_tx_level", tx_lvl, 0);
    chk("rst_rx_data", rx_data, 0);
    // single RX read of 0xA5 followed by single TX write of 0x3C
    rx_en = 1;
    for (int i = 0; i < 16; i++) begin
      rxf = tbl[i].rxf;
      txe = tbl[i].txe;
      rx_ready = tbl[i].rdy;
      tx_valid = tbl[i].tv;
      tx_data = tbl[i].td;
      if (tbl[i].tv) tx_q.push_back(tbl[i].td);
      tick();
      chk($sformatf("vec%0d_rd", i), rd, tbl[i].e_rd);
      chk($sformatf("vec%0d_wr", i), wr, tbl[i].e_wr);
      chk($sformatf("vec%0d_rx_level", i), rx_lvl, tbl[i].e_rxl);
      chk($sformatf("vec%0d_tx_level", i), tx_lvl, tbl[i].e_txl);
      if (tbl[i].cb) chk($sformatf("vec%0d_bus", i), bus, tbl[i].e_bus);
    end
    tx_valid = 0;
    rx_ready = 0;
    txe = 0;
    // reset while in WR with 3 bytes queued
    do_reset();
    for (int k = 0; k < 3; k++) begin
      tx_valid = 1;
      tx_data = 8'h10 + 8'(k);
      tx_q.push_back(tx_data);
      tick();
    end
    tx_valid = 0;
    chk("mwr_level3", tx_lvl, 3);
    txe = 1;
    for (int k = 0; k < 20 && !wr; k++) tick();
    chk("mwr_wr_reached", wr, 1);
    tick();
    rst_n = 0;
    tb_park = 1;
    txe = 0;
    tick();
    chk("mwr_wr", wr, 0);
    chk("mwr_bus_released", bus, 8'h00);
    chk("mwr_tx_level", tx_lvl, 0);
    chk("mwr_tx_ready", tx_ready, 1);
    rst_n = 1;
    tb_park = 0;
    tx_q.delete();
    repeat (3) tick();
    chk("mwr_no_wr", wr, 0);
    // contention: expect RD, WR alternating
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tx_valid = 1;
      tx_data = 8'h40 + 8'(k);
      tx_q.push_back(tx_data);
      tick();
    end
    tx_valid = 0;
    rx_ready = 1;
    rxf = 1;
    txe = 1;
    for (int k = 0; k < 200 && grants.size() < 8; k++) tick();
    rxf = 0;
    for (int i = 0; i < 8; i++)
      chk($sformatf("grant%0d", i), i < grants.size() ? grants[i] : 2, (i % 2 == 0) ? 1 : 0);
    repeat (30) tick();
    chk("cont_tx_level", tx_lvl, 0);
    chk("cont_tx_q", tx_q.size(), 0);
    chk("cont_rx_level", rx_lvl, 0);
    chk("cont_rx_q", rx_q.size(), 0);
    txe = 0;
    rx_ready = 0;
    // RX full
    do_reset();
    rxf = 1;
    repeat (120) tick();
    chk("rxfull_reads", n_rd_rise, 16);
    chk("rxfull_level", rx_lvl, 16);
    chk("rxfull_rd_low", rd, 0);
    rx_ready = 1;
    tick();
    rx_ready = 0;
    repeat (20) tick();
    chk("rxfull_one_more", n_rd_rise, 17);
    chk("rxfull_level2", rx_lvl, 16);
    rxf = 0;
    rx_ready = 1;
    repeat (20) tick();
    chk("rxfull_drained", rx_lvl, 0);
    chk("rxfull_q", rx_q.size(), 0);
    rx_ready = 0;
    // TX full
    do_reset();
    for (int k = 0; k < 16; k++) begin
      tx_valid = 1;
      tx_data = 8'(k * 7 + 1);
      tx_q.push_back(tx_data);
      tick();
    end
    chk("txfull_ready", tx_ready, 0);
    chk("txfull_level", tx_lvl, 16);
    tx_data = 8'hEE;
    tick();
    tx_valid = 0;
    chk("txfull_17th_ignored", tx_lvl, 16);
    txe = 1;
    for (int k = 0; k < 150 && tx_lvl != 0; k++) tick();
    repeat (3) tick();
    chk("txfull_drained", tx_lvl, 0);
    chk("txfull_writes", n_wr_rise, 16);
    chk("txfull_q", tx_q.size(), 0);
    chk("txfull_ready_again", tx_ready, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
